// File: rtl/lse_log2lin.sv
// Log2-domain to linear-domain decoder: 2^x ~= (1 + F + corr(F)) * 2^I, 2-stage valid/ready pipeline.
// Define LSE_LOG2LIN_ROUND_EN to round right shifts to nearest (ties up) instead of truncating.
module lse_log2lin #(
  parameter int WIDTH         = 24,
  parameter int FRAC_BITS     = 10,
  parameter int LUT_PRECISION = 10,
  parameter int OUT_WIDTH     = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [WIDTH-1:0]            i_log_value,
  input  logic [16*LUT_PRECISION-1:0] i_clut_values,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [OUT_WIDTH-1:0]        o_linear,
  output logic                        o_sat
);

  localparam int IW = WIDTH - FRAC_BITS;
  localparam int MW = FRAC_BITS + 3;
  localparam int ML = FRAC_BITS + 1;
  localparam logic signed [IW-1:0] I_MIN   = IW'(-(FRAC_BITS + 1));
  localparam logic signed [IW-1:0] I_MAX   = IW'(OUT_WIDTH - FRAC_BITS - 1);
  localparam logic signed [MW-1:0] M_MAX   = MW'((1 << ML) - 1);
  localparam logic [WIDTH-1:0]     NEG_INF = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [ML-1:0] clamp_mant(input logic signed [MW-1:0] v);
    if (v < 0)          return '0;
    else if (v > M_MAX) return '1;
    else                return v[ML-1:0];
  endfunction

  function automatic logic [OUT_WIDTH-1:0] rshift_round(input logic [OUT_WIDTH-1:0] v,
                                                        input logic [IW-1:0] sh);
    logic [OUT_WIDTH-1:0] acc;
    acc = v;
`ifdef LSE_LOG2LIN_ROUND_EN
    acc = acc + (OUT_WIDTH'(1) << (sh - 1'b1));
`endif
    return acc >> sh;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] scale_mant(input logic [ML-1:0] m,
                                                      input logic signed [IW-1:0] e);
    logic [OUT_WIDTH-1:0] mx;
    logic [IW-1:0]        sh;
    mx = OUT_WIDTH'(m);
    sh = -e;
    if (!e[IW-1]) return mx << e;
    else          return rshift_round(mx, sh);
  endfunction

  logic                  vld_p1_q, vld_p1_d;
  logic [ML-1:0]         mant_p1_q, mant_p1_d;
  logic signed [IW-1:0]  exp_p1_q, exp_p1_d;
  logic                  zero_p1_q, zero_p1_d;
  logic                  satf_p1_q, satf_p1_d;
  logic                  vld_p2_q, vld_p2_d;
  logic [OUT_WIDTH-1:0]  lin_p2_q, lin_p2_d;
  logic                  sat_p2_q, sat_p2_d;

  logic                      s2_can_load;
  logic                      accept;
  logic signed [IW-1:0]      int_part;
  logic [FRAC_BITS-1:0]      frac;
  logic [FRAC_BITS:0]        idx_sum;
  logic [4:0]                idx_full;
  logic [3:0]                idx;
  logic signed [LUT_PRECISION-1:0] corr;
  logic signed [MW-1:0]      m_raw;

  always_comb begin
    s2_can_load = !vld_p2_q || i_ready;
    o_ready     = !vld_p1_q || s2_can_load;
    accept      = i_valid && o_ready;

    // S1: decode integer/fraction, look up correction, build clamped mantissa
    int_part = i_log_value[WIDTH-1:FRAC_BITS];
    frac     = i_log_value[FRAC_BITS-1:0];
    idx_sum  = {1'b0, frac} + (FRAC_BITS+1)'(1 << (FRAC_BITS - 5));
    idx_full = 5'(idx_sum >> (FRAC_BITS - 4));
    idx      = idx_full[4] ? 4'd15 : idx_full[3:0];
    corr     = i_clut_values[idx*LUT_PRECISION +: LUT_PRECISION];
    m_raw    = MW'(1 << FRAC_BITS) + MW'(frac) + MW'(corr);

    vld_p1_d  = o_ready ? i_valid : vld_p1_q;
    mant_p1_d = mant_p1_q;
    exp_p1_d  = exp_p1_q;
    zero_p1_d = zero_p1_q;
    satf_p1_d = satf_p1_q;
    if (accept) begin
      mant_p1_d = clamp_mant(m_raw);
      exp_p1_d  = int_part;
      zero_p1_d = (i_log_value == NEG_INF) || (int_part < I_MIN);
      satf_p1_d = int_part > I_MAX;
    end

    // S2: shift into the output register, with zero/saturation overrides
    vld_p2_d = s2_can_load ? vld_p1_q : vld_p2_q;
    lin_p2_d = lin_p2_q;
    sat_p2_d = sat_p2_q;
    if (s2_can_load && vld_p1_q) begin
      if (zero_p1_q) begin
        lin_p2_d = '0;
        sat_p2_d = 1'b0;
      end else if (satf_p1_q) begin
        lin_p2_d = '1;
        sat_p2_d = 1'b1;
      end else begin
        lin_p2_d = scale_mant(mant_p1_q, exp_p1_q);
        sat_p2_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      lin_p2_q <= '0;
      sat_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      lin_p2_q <= lin_p2_d;
      sat_p2_q <= sat_p2_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mant_p1_q <= mant_p1_d;
    exp_p1_q  <= exp_p1_d;
    zero_p1_q <= zero_p1_d;
    satf_p1_q <= satf_p1_d;
  end

  assign o_valid  = vld_p2_q;
  assign o_linear = lin_p2_q;
  assign o_sat    = sat_p2_q;

endmodule
